// File: rtl/fp_result_arbiter_pkg.sv
// Shared FP writeback definitions: exception-flag layout, NaN-boxing and canonical NaN constants.
package fp_result_arbiter_pkg;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   localparam logic [31:0] NAN_BOX_UPPER   = 32'hFFFF_FFFF;
   localparam logic [63:0] CANONICAL_NAN_S = 64'hFFFF_FFFF_7FC0_0000;
   localparam logic [63:0] CANONICAL_NAN_D = 64'h7FF8_0000_0000_0000;

   function automatic logic is_nan_s(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   function automatic logic is_nan_d(input logic [63:0] v);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
   endfunction

endpackage

// File: rtl/fp_result_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr; ptr moves past the winner on advance.
module fp_rr_arbiter
   import fp_result_arbiter_pkg::*;
#(
   parameter int N  = 5,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] grant_idx;
   logic [PW-1:0] idx;
   logic [PW:0]   sum;
   logic          found;
   logic [PW-1:0] ptr_next;

   // Scan from ptr, wrapping modulo N, and grant the first requester.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      sum       = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW + 1)'(i);
         if (sum >= (PW + 1)'(N)) begin
            idx = PW'(sum - (PW + 1)'(N));
         end else begin
            idx = sum[PW-1:0];
         end
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

   // Next pointer is one past the winner, wrapping after the last index.
   always_comb begin
      if (grant_idx == PW'(N - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = grant_idx + PW'(1);
      end
   end

   // Pointer register only moves when a grant is actually consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= ptr_next;
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/fp_result_arbiter.sv
// FP result return path: round-robin pick of a done unit, NaN-box singles, one-entry writeback stage, sticky fflags.
// Optional FP_CANONICAL_NAN_EN replaces NaN results with the canonical NaN before capture.
module fp_result_arbiter
   import fp_result_arbiter_pkg::*;
#(
   parameter int FP_NUM_UNITS = 5,
   parameter int ID_W         = 3,
   parameter int FLEN         = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [FP_NUM_UNITS-1:0]      unit_done,
   input  logic [FP_NUM_UNITS*ID_W-1:0] unit_id,
   input  logic [FP_NUM_UNITS*FLEN-1:0] unit_rd,
   input  logic [FP_NUM_UNITS-1:0]      unit_single,
   input  logic [FP_NUM_UNITS*5-1:0]    unit_fflags,
   output logic [FP_NUM_UNITS-1:0]      unit_ack,
   output logic                         wb_done,
   output logic [ID_W-1:0]              wb_id,
   output logic [FLEN-1:0]              wb_rd,
   output logic [4:0]                   wb_fflags,
   input  logic                         wb_ack,
   input  logic                         fflags_clr,
   output logic [4:0]                   fflags_acc
);

   localparam int PW = (FP_NUM_UNITS > 1) ? $clog2(FP_NUM_UNITS) : 1;

   logic [FP_NUM_UNITS-1:0] grant;
   logic [PW-1:0]           rr_ptr_unused;
   logic                    accept;
   logic                    advance;
   logic [ID_W-1:0]         win_id;
   logic [FLEN-1:0]         win_rd;
   logic                    win_single;
   logic [4:0]              win_flags;
   logic [FLEN-1:0]         boxed;
   logic [FLEN-1:0]         cap_rd;
   logic                    retire;
   fflags_t                 acc;

   // Reset gates the ack so nothing is consumed in the reset cycle.
   assign accept   = (~wb_done | wb_ack) & ~rst;
   assign unit_ack = grant & {FP_NUM_UNITS{accept}};
   assign advance  = |unit_ack;
   assign retire   = wb_done & wb_ack;

   fp_rr_arbiter #(.N(FP_NUM_UNITS), .PW(PW)) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (unit_done),
      .advance (advance),
      .grant   (grant),
      .ptr     (rr_ptr_unused)
   );

   // One-hot AND-OR select of the winning unit's fields.
   always_comb begin
      win_id     = '0;
      win_rd     = '0;
      win_single = 1'b0;
      win_flags  = '0;
      for (int i = 0; i < FP_NUM_UNITS; i++) begin
         win_id     = win_id | (unit_id[i*ID_W +: ID_W] & {ID_W{grant[i]}});
         win_rd     = win_rd | (unit_rd[i*FLEN +: FLEN] & {FLEN{grant[i]}});
         win_single = win_single | (unit_single[i] & grant[i]);
         win_flags  = win_flags | (unit_fflags[i*5 +: 5] & {5{grant[i]}});
      end
   end

   // NaN-box singles; optionally canonicalise NaN payloads.
   always_comb begin
      if (win_single) begin
         boxed = FLEN'({NAN_BOX_UPPER, win_rd[31:0]});
      end else begin
         boxed = win_rd;
      end
`ifdef FP_CANONICAL_NAN_EN
      if (win_single && is_nan_s(win_rd[31:0])) begin
         cap_rd = FLEN'(CANONICAL_NAN_S);
      end else if (!win_single && is_nan_d(win_rd[63:0])) begin
         cap_rd = FLEN'(CANONICAL_NAN_D);
      end else begin
         cap_rd = boxed;
      end
`else
      cap_rd = boxed;
`endif
   end

   // Output stage: reload on ack (no bubble), drain on wb_ack with nothing to refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_done   <= 1'b0;
         wb_id     <= '0;
         wb_rd     <= '0;
         wb_fflags <= 5'b00000;
      end else if (advance) begin
         wb_done   <= 1'b1;
         wb_id     <= win_id;
         wb_rd     <= cap_rd;
         wb_fflags <= win_flags;
      end else if (wb_ack) begin
         wb_done   <= 1'b0;
      end else begin
         wb_done   <= wb_done;
      end
   end

   // Sticky flags: a same-cycle clear keeps only the retiring result's flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (retire) begin
         acc <= fflags_t'((fflags_clr ? 5'b00000 : 5'(acc)) | wb_fflags);
      end else if (fflags_clr) begin
         acc <= '0;
      end else begin
         acc <= acc;
      end
   end

   assign fflags_acc = acc;

endmodule

// File: tb/tb_fp_result_arbiter.sv
// Directed self-checking bench for fp_result_arbiter (expectations follow FP_CANONICAL_NAN_EN when defined).
module tb_fp_result_arbiter;

   localparam int N    = 5;
   localparam int ID_W = 3;
   localparam int FLEN = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      unit_done;
   logic [N*ID_W-1:0] unit_id;
   logic [N*FLEN-1:0] unit_rd;
   logic [N-1:0]      unit_single;
   logic [N*5-1:0]    unit_fflags;
   logic [N-1:0]      unit_ack;
   logic              wb_done;
   logic [ID_W-1:0]   wb_id;
   logic [FLEN-1:0]   wb_rd;
   logic [4:0]        wb_fflags;
   logic              wb_ack;
   logic              fflags_clr;
   logic [4:0]        fflags_acc;

   int checks = 0;
   int errors = 0;

   fp_result_arbiter #(.FP_NUM_UNITS(N), .ID_W(ID_W), .FLEN(FLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .unit_done   (unit_done),
      .unit_id     (unit_id),
      .unit_rd     (unit_rd),
      .unit_single (unit_single),
      .unit_fflags (unit_fflags),
      .unit_ack    (unit_ack),
      .wb_done     (wb_done),
      .wb_id       (wb_id),
      .wb_rd       (wb_rd),
      .wb_fflags   (wb_fflags),
      .wb_ack      (wb_ack),
      .fflags_clr  (fflags_clr),
      .fflags_acc  (fflags_acc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_unit(input int u, input logic d, input logic [ID_W-1:0] id,
                           input logic [FLEN-1:0] rd, input logic s, input logic [4:0] f);
      unit_done[u]             = d;
      unit_id[u*ID_W +: ID_W]  = id;
      unit_rd[u*FLEN +: FLEN]  = rd;
      unit_single[u]           = s;
      unit_fflags[u*5 +: 5]    = f;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      unit_done   = '0;
      unit_id     = '0;
      unit_rd     = '0;
      unit_single = '0;
      unit_fflags = '0;
      wb_ack      = 1'b0;
      fflags_clr  = 1'b0;
      step();
      step();
      check("rst_wb_done", 64'(wb_done), 64'd0);
      check("rst_wb_id", 64'(wb_id), 64'd0);
      check("rst_wb_rd", wb_rd, 64'd0);
      check("rst_wb_fflags", 64'(wb_fflags), 64'd0);
      check("rst_fflags_acc", 64'(fflags_acc), 64'd0);
      check("rst_unit_ack", 64'(unit_ack), 64'd0);
      rst = 1'b0;

      // single-precision winner, boxed
      set_unit(2, 1'b1, 3'd5, 64'h0000_0000_3F80_0000, 1'b1, 5'b00000);
      wb_ack = 1'b1;
      settle();
      check("single_ack", 64'(unit_ack), 64'h04);
      step();
      set_unit(2, 1'b0, 3'd0, 64'd0, 1'b0, 5'b00000);
      check("single_done", 64'(wb_done), 64'd1);
      check("single_id", 64'(wb_id), 64'd5);
      check("single_rd", wb_rd, 64'hFFFF_FFFF_3F80_0000);
      settle();
      check("single_ack_once", 64'(unit_ack), 64'h00);
      step();
      check("drain_done", 64'(wb_done), 64'd0);
      check("drain_rd_stale", wb_rd, 64'hFFFF_FFFF_3F80_0000);

      // round robin with all units done continuously
      do_reset();
      for (int u = 0; u < N; u++) set_unit(u, 1'b1, 3'(u), 64'(u), 1'b0, 5'b00000);
      wb_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         settle();
         check($sformatf("rr_ack_%0d", k), 64'(unit_ack), 64'(5'b00001 << (k % N)));
         step();
         check($sformatf("rr_done_%0d", k), 64'(wb_done), 64'd1);
         check($sformatf("rr_id_%0d", k), 64'(wb_id), 64'(k % N));
      end

      // backpressure with pointer at 2
      do_reset();
      unit_done = '0;
      set_unit(1, 1'b1, 3'd1, 64'h4000_0000_0000_0000, 1'b0, 5'b00000);
      wb_ack = 1'b0;
      settle();
      check("bp_first_ack", 64'(unit_ack), 64'h02);
      step();
      set_unit(1, 1'b1, 3'd6, 64'h4010_0000_0000_0000, 1'b0, 5'b00000);
      set_unit(3, 1'b1, 3'd3, 64'h4020_0000_0000_0000, 1'b0, 5'b00000);
      for (int c = 0; c < 4; c++) begin
         settle();
         check($sformatf("bp_ack_%0d", c), 64'(unit_ack), 64'h00);
         step();
         check($sformatf("bp_rd_%0d", c), wb_rd, 64'h4000_0000_0000_0000);
         check($sformatf("bp_id_%0d", c), 64'(wb_id), 64'd1);
      end
      wb_ack = 1'b1;
      settle();
      check("bp_release_ack", 64'(unit_ack), 64'h08);
      step();
      unit_done[3] = 1'b0;
      check("bp_release_id", 64'(wb_id), 64'd3);
      settle();
      check("bp_next_ack", 64'(unit_ack), 64'h02);
      step();
      unit_done[1] = 1'b0;
      check("bp_next_id", 64'(wb_id), 64'd6);
      check("bp_next_rd", wb_rd, 64'h4010_0000_0000_0000);

      // flag accumulation and clear
      do_reset();
      unit_done = '0;
      wb_ack = 1'b1;
      set_unit(0, 1'b1, 3'd1, 64'h1, 1'b0, 5'b00001);
      step();
      unit_done[0] = 1'b0;
      set_unit(4, 1'b1, 3'd2, 64'h2, 1'b0, 5'b10000);
      step();
      unit_done[4] = 1'b0;
      check("flags_first", 64'(fflags_acc), 64'h01);
      check("flags_wb", 64'(wb_fflags), 64'h10);
      step();
      check("flags_accum", 64'(fflags_acc), 64'h11);
      check("flags_drained", 64'(wb_done), 64'd0);
      set_unit(2, 1'b1, 3'd3, 64'h3, 1'b0, 5'b00100);
      step();
      unit_done[2] = 1'b0;
      check("flags_no_retire", 64'(fflags_acc), 64'h11);
      fflags_clr = 1'b1;
      step();
      check("flags_clr_retire", 64'(fflags_acc), 64'h04);
      wb_ack = 1'b0;
      step();
      fflags_clr = 1'b0;
      check("flags_clr_only", 64'(fflags_acc), 64'h00);

      // reset while a result is held
      do_reset();
      wb_ack = 1'b1;
      set_unit(0, 1'b1, 3'd2, 64'h5, 1'b0, 5'b11111);
      set_unit(3, 1'b1, 3'd3, 64'h6, 1'b0, 5'b00000);
      step();
      unit_done[0] = 1'b0;
      step();
      unit_done[3] = 1'b0;
      check("mid_acc_before", 64'(fflags_acc), 64'h1F);
      check("mid_done_before", 64'(wb_done), 64'd1);
      set_unit(3, 1'b1, 3'd4, 64'h7, 1'b0, 5'b00000);
      set_unit(4, 1'b1, 3'd5, 64'h8, 1'b0, 5'b00000);
      rst = 1'b1;
      settle();
      check("mid_rst_ack", 64'(unit_ack), 64'h00);
      step();
      check("mid_rst_done", 64'(wb_done), 64'd0);
      check("mid_rst_acc", 64'(fflags_acc), 64'd0);
      rst = 1'b0;
      settle();
      check("mid_rst_ptr", 64'(unit_ack), 64'h08);

      // NaN handling
      do_reset();
      unit_done = '0;
      wb_ack = 1'b1;
      set_unit(0, 1'b1, 3'd1, 64'h7FF0_0000_0000_0001, 1'b0, 5'b10000);
      step();
      unit_done[0] = 1'b0;
      set_unit(1, 1'b1, 3'd2, 64'h1234_5678_7FC0_0001, 1'b1, 5'b00000);
`ifdef FP_CANONICAL_NAN_EN
      check("nan_d", wb_rd, 64'h7FF8_0000_0000_0000);
`else
      check("nan_d", wb_rd, 64'h7FF0_0000_0000_0001);
`endif
      check("nan_d_flags", 64'(wb_fflags), 64'h10);
      step();
      unit_done[1] = 1'b0;
`ifdef FP_CANONICAL_NAN_EN
      check("nan_s", wb_rd, 64'hFFFF_FFFF_7FC0_0000);
`else
      check("nan_s", wb_rd, 64'hFFFF_FFFF_7FC0_0001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
